// File: rtl/free_list_pkg.sv
// free_list_pkg: shared rename-stage types and sizes used by the free list.
// Latency: n/a (types, constants and a pointer helper only).
// Backpressure: n/a.
//
// Contents:
//   NUM_PHYS_REGS / NUM_ARCH_REGS / PHYS_REG_BITS - machine-wide register sizes
//   TAG                                           - rename tag {phys_reg, valid, ready}
//   FL_DEPTH / PTR_W / CNT_W                      - free-list geometry
//   fl_ptr_inc()                                  - modulo-FL_DEPTH pointer increment
package free_list_pkg;

  localparam int NUM_PHYS_REGS = 64;
  localparam int NUM_ARCH_REGS = 32;
  localparam int PHYS_REG_BITS = $clog2(NUM_PHYS_REGS);

  // Rename tag: physical register index plus the ready bit used by the
  // reservation stations. valid qualifies the tag on the allocation path.
  typedef struct packed {
    logic [PHYS_REG_BITS-1:0] phys_reg;
    logic                     valid;
    logic                     ready;
  } TAG;

  localparam int TAG_BITS = $bits(TAG);

  localparam int FL_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam int PTR_W    = $clog2(FL_DEPTH);
  localparam int CNT_W    = $clog2(FL_DEPTH + 1);

  // Explicit compare-and-clear so the ring stays correct even when
  // FL_DEPTH is not a power of two.
  function automatic logic [PTR_W-1:0] fl_ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FL_DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/free_list.sv
// free_list: R10K-style physical-register free list (circular FIFO of free tags).
// Latency: alloc_tag is combinational from state; frees become allocatable next cycle.
// Backpressure: none; alloc_en while empty is a no-op, dispatch stalls on !alloc_tag.valid.
//
// Ports:
//   clock, reset      - system clock, synchronous active-high reset
//   interrupt         - restore speculative head/count to the committed state
//   alloc_en          - dispatch consumes alloc_tag this cycle
//   alloc_tag         - head entry {phys_reg, valid=!empty, ready=0}
//   empty, free_count - occupancy of the speculative list
//   retire_en         - retiring instruction with a real destination
//   retire_t_old      - tag freed by retirement (only phys_reg is kept)
//
// Build option: define FL_RETIRE_BYPASS_EN to forward a retiring T_old
// straight to alloc_tag while the list is empty.
module free_list
  import free_list_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                interrupt,
  input  logic                alloc_en,
  output logic [TAG_BITS-1:0] alloc_tag,
  output logic                empty,
  output logic [CNT_W-1:0]    free_count,
  input  logic                retire_en,
  input  logic [TAG_BITS-1:0] retire_t_old
);

  // Ring storage and pointers. tail and arch_head both advance only on
  // retirement, so the committed list always spans the whole ring from
  // arch_head.
  logic [PHYS_REG_BITS-1:0] entries [FL_DEPTH];
  logic [PTR_W-1:0]         head;
  logic [PTR_W-1:0]         tail;
  logic [PTR_W-1:0]         arch_head;
  logic [CNT_W-1:0]         count;

  TAG               retire_tag;
  TAG               head_tag;
  logic             list_empty;
  logic             bypass_hit;
  logic             do_alloc;
  logic             do_retire;
  logic             write_entry;
  logic [CNT_W-1:0] count_nxt;
  logic             unused_retire_bits;

  assign retire_tag         = TAG'(retire_t_old);
  assign unused_retire_bits = ^{retire_tag.valid, retire_tag.ready};
  assign list_empty         = (count == '0);

  always_comb begin
    bypass_hit = 1'b0;
`ifdef FL_RETIRE_BYPASS_EN
    bypass_hit = list_empty && retire_en && !interrupt;
`endif

    head_tag          = '0;
    head_tag.phys_reg = bypass_hit ? retire_tag.phys_reg : entries[head];
    head_tag.valid    = !list_empty || bypass_hit;
    head_tag.ready    = 1'b0;

    // Interrupt wins over both alloc and retire; a retire in the same cycle
    // is dropped, matching the map table.
    do_alloc  = !interrupt && alloc_en && head_tag.valid;
    do_retire = !interrupt && retire_en;

    // A bypassed tag that is consumed in the same cycle never lands in the
    // ring; the slot at tail is skipped over unchanged.
    write_entry = do_retire && !(bypass_hit && alloc_en);

    if (interrupt) begin
      count_nxt = CNT_W'(FL_DEPTH);
    end else begin
      count_nxt = count + CNT_W'(do_retire) - CNT_W'(do_alloc);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      arch_head <= '0;
      count     <= CNT_W'(FL_DEPTH);
    end else begin
      count <= count_nxt;
      if (interrupt) begin
        head <= arch_head;
      end else begin
        if (do_alloc) begin
          head <= fl_ptr_inc(head);
        end
        if (do_retire) begin
          tail      <= fl_ptr_inc(tail);
          arch_head <= fl_ptr_inc(arch_head);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        entries[i] <= PHYS_REG_BITS'(NUM_ARCH_REGS + i);
      end
    end else if (write_entry) begin
      entries[tail] <= retire_tag.phys_reg;
    end
  end

  // Retiring with a full list means a retire without a matching allocation.
  always @(posedge clock) begin
    if (!reset && retire_en && !interrupt) begin
      assert (count != CNT_W'(FL_DEPTH));
    end
  end

  assign alloc_tag  = head_tag;
  assign empty      = list_empty;
  assign free_count = count;

endmodule
